// File: rtl/mdio_master_pkg.sv
// Shared Clause-22 MDIO constants, FSM state type and the frame builder
// used by the management-frame engine.
package mdio_master_pkg;

  localparam int MDIO_PREAMBLE_BITS = 32;
  localparam int MDIO_FRAME_BITS    = 64;
  localparam int MDIO_ADDR_W        = 5;
  localparam int MDIO_DATA_W        = 16;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_TA_WR = 2'b10;

  // Slot indices where a read frame releases the pin, where data begins, and the final slot.
  localparam logic [5:0] MDIO_SLOT_RELEASE = 6'd46;
  localparam logic [5:0] MDIO_SLOT_DATA    = 6'd48;
  localparam logic [5:0] MDIO_SLOT_LAST    = 6'd63;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdio_state_e;

  function automatic logic [MDIO_FRAME_BITS-1:0] mdio_frame(
    input logic                   is_wr,
    input logic [MDIO_ADDR_W-1:0] phy_addr,
    input logic [MDIO_ADDR_W-1:0] reg_addr,
    input logic [MDIO_DATA_W-1:0] data
  );
    return {{MDIO_PREAMBLE_BITS{1'b1}},
            MDIO_ST,
            (is_wr ? MDIO_OP_WR : MDIO_OP_RD),
            phy_addr,
            reg_addr,
            (is_wr ? MDIO_TA_WR : 2'b00),
            (is_wr ? data : {MDIO_DATA_W{1'b0}})};
  endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Request/response bundle between the PHY configuration controller
// (master) and the MDIO frame engine (slave).
interface mdio_master_if;
  import mdio_master_pkg::*;

  logic [MDIO_ADDR_W-1:0] addr;
  logic [MDIO_DATA_W-1:0] wr_data;
  logic                   rd_request;
  logic                   wr_request;
  logic                   ready;
  logic [MDIO_DATA_W-1:0] rd_data;

  modport master (
    output addr, wr_data, rd_request, wr_request,
    input  ready, rd_data
  );

  modport slave (
    input  addr, wr_data, rd_request, wr_request,
    output ready, rd_data
  );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: serialises one read or write frame per request,
// MDC at clock/2, MDIO changes only while MDC is low.
module mdio_master
  import mdio_master_pkg::*;
#(
  parameter logic [MDIO_ADDR_W-1:0] PHY_ADDR = 5'd0
) (
  input  logic          clock,
  input  logic          reset,
  mdio_master_if.slave  bus,
  inout  wire           mdio_pin,
  output logic          mdc_pin
);

  mdio_state_e                state, state_nxt;
  logic [5:0]                 bit_cnt;
  logic [5:0]                 cnt_nxt;
  logic                       phase;
  logic [MDIO_FRAME_BITS-1:0] frame_sr;
  logic [MDIO_DATA_W-1:0]     rd_sr;
  logic [MDIO_DATA_W-1:0]     rd_data_q;
  logic                       is_wr;
  logic                       oe;
  logic                       start;
  logic                       frame_end;

  assign start     = (state == ST_IDLE) && (bus.rd_request || bus.wr_request);
  assign frame_end = (state == ST_BUSY) && phase && (bit_cnt == MDIO_SLOT_LAST);
  assign cnt_nxt   = bit_cnt + 6'd1;

  // Combinational on the requests so upstream never sees ready in its own request cycle.
  assign bus.ready   = (state == ST_IDLE) && !bus.rd_request && !bus.wr_request;
  assign bus.rd_data = rd_data_q;
  assign mdio_pin    = oe ? frame_sr[MDIO_FRAME_BITS-1] : 1'bz;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next-state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start)     state_nxt = ST_BUSY;
      ST_BUSY: if (frame_end) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt   <= '0;
      phase     <= 1'b0;
      frame_sr  <= '0;
      rd_sr     <= '0;
      rd_data_q <= '0;
      is_wr     <= 1'b0;
      oe        <= 1'b0;
      mdc_pin   <= 1'b0;
    end else if (start) begin
      // A simultaneous read and write request resolves to the write.
      bit_cnt  <= '0;
      phase    <= 1'b0;
      mdc_pin  <= 1'b0;
      oe       <= 1'b1;
      is_wr    <= bus.wr_request;
      frame_sr <= mdio_frame(bus.wr_request, PHY_ADDR, bus.addr, bus.wr_data);
    end else if (state == ST_BUSY) begin
      if (!phase) begin
        // MDC rises here; the PHY has had a full clock since the previous rise to present data.
        phase   <= 1'b1;
        mdc_pin <= 1'b1;
        if (!is_wr && (bit_cnt >= MDIO_SLOT_DATA))
          rd_sr <= {rd_sr[MDIO_DATA_W-2:0], mdio_pin};
      end else begin
        phase   <= 1'b0;
        mdc_pin <= 1'b0;
        if (frame_end) begin
          oe <= 1'b0;
          if (!is_wr) rd_data_q <= rd_sr;
        end else begin
          bit_cnt  <= cnt_nxt;
          frame_sr <= {frame_sr[MDIO_FRAME_BITS-2:0], 1'b0};
          oe       <= is_wr || (cnt_nxt < MDIO_SLOT_RELEASE);
        end
      end
    end
  end

endmodule
